// File: rtl/uart_rxd_fifo.sv
// uart_rxd_fifo: 8N1 UART receiver feeding a show-ahead receive FIFO, with framing/overrun flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and add the parity_err pulse output.
module uart_rxd_fifo #(
  parameter int unsigned CLK_F      = 12_000_000,
  parameter int unsigned BPS        = 9600,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          overrun
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST = 16'((CLK_F / BPS) - 1);
  localparam logic [15:0] HALF_CNT = 16'(((CLK_F / BPS) / 2) - 1);
  localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;
`endif

  state_t        state_r;
  logic          rx_meta_r;
  logic          rx_s_r;
  logic          rx_prev_r;
  logic [15:0]   cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          frame_err_r;
  logic          overrun_r;
  logic          par_bad_s;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_r;
  logic          parity_err_r;
`endif

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          rd_valid_r;
  logic          full_r;

  logic          stop_hit_s;
  logic          byte_ok_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_full_s;

`ifdef UART_RX_PARITY_EN
  assign par_bad_s = ^{shift_r, par_bit_r};
`else
  assign par_bad_s = 1'b0;
`endif

  // A full FIFO still accepts the byte when the consumer pops on the same edge.
  assign stop_hit_s  = (state_r == STOP) && (cnt_r == 16'd0);
  assign byte_ok_s   = stop_hit_s && rx_s_r && !par_bad_s;
  assign pop_s       = rd_en && rd_valid_r;
  assign push_s      = byte_ok_s && (!full_r || pop_s);
  assign drop_full_s = byte_ok_s && full_r && !pop_s;

  // Two-flop synchronizer plus one delayed copy for start-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s_r    <= rx_meta_r;
      rx_prev_r <= rx_s_r;
    end
  end

  // Receive FSM: mid-bit sampling, byte assembly and error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= 16'd0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      if (drop_full_s) begin
        overrun_r <= 1'b1;
      end else if (clr_err) begin
        overrun_r <= 1'b0;
      end
      if (cnt_r != 16'd0) begin
        cnt_r <= cnt_r - 16'd1;
      end
      case (state_r)
        IDLE: begin
          if (rx_prev_r && !rx_s_r) begin
            cnt_r   <= HALF_CNT;
            state_r <= START;
          end
        end
        START: begin
          if (cnt_r == 16'd0) begin
            if (!rx_s_r) begin
              cnt_r     <= BIT_LAST;
              bit_idx_r <= 3'd0;
              state_r   <= DATA;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        DATA: begin
          if (cnt_r == 16'd0) begin
            shift_r <= {rx_s_r, shift_r[7:1]};
            cnt_r   <= BIT_LAST;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_r <= PARITY;
`else
              state_r <= STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_r == 16'd0) begin
            par_bit_r <= rx_s_r;
            cnt_r     <= BIT_LAST;
            state_r   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt_r == 16'd0) begin
            state_r     <= IDLE;
            frame_err_r <= !rx_s_r;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= par_bad_s;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 16'd0;
        end
      endcase
    end
  end

  // Occupancy after this edge's push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO pointers and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= CNT_ZERO;
      rd_valid_r <= 1'b0;
      full_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_next_s;
      rd_valid_r <= (count_next_s != CNT_ZERO);
      full_r     <= (count_next_s == CNT_FULL);
    end
  end

  // Storage array; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  assign rd_data    = rd_valid_r ? mem_r[rd_ptr_r] : 8'h00;
  assign rd_valid   = rd_valid_r;
  assign full       = full_r;
  assign fifo_count = count_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`endif

endmodule
